cobro_pago: RTL and testbench
=============================

# cobro_pago

Payment execution block that sits downstream of the payment-method menu. It consumes the menu's one-hot selection (EFE = cash, TAR = card) and collects coins against a latched price or waits for a card authorization. It then pays out change one unit per cycle and reports completion (OK) or failure (ERR) back to the menu/controller.

## Interface
Parameters:
- W, 8, width of price, credit and change quantities
- TMO, 200, card-authorization timeout in clock cycles (≥ 2)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- EFE  input  1  cash method selected (level from menu)
- TAR  input  1  card method selected (level from menu)
- PRECIO  input  W  price, sampled only on leaving idle
- M1, M5, M10  input  1 each  coin-inserted pulses, values 1/5/10
- CAN  input  1  user cancel
- APR  input  1  card approved pulse
- RCH  input  1  card rejected pulse
- OK  output  1  payment complete, 1-cycle pulse
- ERR  output  1  payment failed/cancelled, 1-cycle pulse
- DEV  output  1  return one unit of change, high one cycle per unit
- SALDO  output  W  accumulated cash credit
- OCUP  output  1  block busy (any state except idle)

## Operation
- States: ESP (idle), CAJA (collecting cash), TARJ (awaiting card), VUEL (returning coins), FIN (success), FALLO (failure). Moore FSM; all outputs decode from registered state/datapath.
- ESP: EFE=1 → CAJA; else TAR=1 → TARJ (EFE wins if both). On either exit, latch PRECIO into price register, clear SALDO, clear cancel flag; TARJ entry also loads the timeout counter with TMO-1.
- CAJA, each cycle:
  - CAN=1 has priority and ignores coins that cycle. Set the cancel flag. Refund = SALDO: go to VUEL if nonzero, else to FALLO.
  - Otherwise sum = SALDO + M1·1 + M5·5 + M10·10, computed in W+1 bits. Coins that arrive together all count.
  - If sum ≥ price: change = sum − price. Go to VUEL if change > 0, else to FIN.
  - Otherwise SALDO ← min(sum, 2^W−1) and stay in CAJA.
- Price 0: the first CAJA cycle goes straight to FIN.
- VUEL: DEV=1 every cycle; the down-counter decrements. When the counter = 1, go to FIN (cancel flag clear) or FALLO (cancel flag set). Exactly N DEV cycles for change N.
- TARJ, priority APR > RCH > CAN > timeout:
  - APR → FIN.
  - RCH, CAN, or timeout counter = 0 → FALLO.
  - The counter decrements each TARJ cycle.
- FIN: OK=1 for one cycle, then ESP. FALLO: ERR=1 for one cycle, then ESP. SALDO cleared on the FIN/FALLO → ESP transition.
- Inputs EFE/TAR are ignored outside ESP; coins are ignored outside CAJA (no credit for late coins).

## Timing
- Reset: state ESP; OK=ERR=DEV=OCUP=0, SALDO=0, counters 0, cancel flag 0 — applied immediately. Reset mid-operation discards credit and change owed without DEV pulses.
- Coin at edge t: SALDO/state updated at t+1.
- Price reached at t with change N: DEV high for cycles t+1…t+N, OK at t+N+1, ESP (OCUP=0) at t+N+2.
- Exact payment at t: OK at t+1, ESP at t+2.
- Card: entry to TARJ at t0 with no response → FALLO at t0+TMO, ERR that cycle. APR in the same cycle as timeout expiry wins.
- OCUP rises the cycle after EFE/TAR is sampled and falls the cycle after OK/ERR.

## Structure
- Package pago_pkg:
  - 3-bit state encodings (ESP=000, CAJA=001, TARJ=010, VUEL=011, FIN=100, FALLO=101; others → ESP)
  - coin value constants V1=1, V5=5, V10=10
- Sub-module contador_desc: W-bit loadable down-counter with load, dec and zero/one flags. Instantiated twice, for change and card timeout.
- Top holds the FSM, price register, SALDO accumulator with saturation, and the cancel flag.

## Test plan
- PRECIO=12, EFE, coins M10 then M5 → SALDO 10, then VUEL with DEV high 3 cycles, OK one cycle, OCUP low after.
- PRECIO=15, EFE, M5+M10 same cycle → no DEV, OK the next cycle, SALDO 15 visible in FIN.
- PRECIO=20, EFE, M5, M1, then CAN with M10 same cycle → 6 DEV pulses, then ERR; the M10 is not credited.
- TAR, APR after 5 cycles → OK; TAR with RCH → ERR; TAR with no response → ERR exactly TMO cycles after TARJ entry.
- PRECIO=0 with EFE → OK on the second cycle after selection; EFE and TAR together → cash path taken.
- Reset asserted during VUEL with 4 units owed → all outputs 0 immediately, state ESP, no further DEV.

Source files
------------

// File: rtl/pago_pkg.sv
// Shared encodings for the payment-execution block: FSM states, coin values
// and the debug snapshot exported by the top.
package pago_pkg;

  typedef enum logic [2:0] {
    ESP   = 3'b000,
    CAJA  = 3'b001,
    TARJ  = 3'b010,
    VUEL  = 3'b011,
    FIN   = 3'b100,
    FALLO = 3'b101
  } estado_t;

  localparam int unsigned V1  = 1;
  localparam int unsigned V5  = 5;
  localparam int unsigned V10 = 10;

  typedef struct packed {
    estado_t estado;
    logic    canc;
    logic    vuel_one;
    logic    vuel_zero;
    logic    tmo_one;
    logic    tmo_zero;
  } dbg_t;

  // Coins arriving in the same cycle all count; the worst case is 16.
  function automatic logic [4:0] valor_monedas(input logic m1, input logic m5,
                                               input logic m10);
    logic [4:0] v;
    v = 5'd0;
    if (m1)  v = v + 5'(V1);
    if (m5)  v = v + 5'(V5);
    if (m10) v = v + 5'(V10);
    return v;
  endfunction

endpackage

// File: rtl/contador_desc.sv
// Loadable W-bit down-counter; holds at zero instead of wrapping.
module contador_desc #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] val,
  input  logic         dec,
  output logic         zero,
  output logic         one
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = val;
    else if (dec && (cnt_q != '0))
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);
  assign one  = (cnt_q == W'(1));

endmodule

// File: rtl/cobro_pago.sv
// Payment execution: collects cash against a latched price or waits for a card
// verdict, returns change one unit per cycle, then pulses OK or ERR.
module cobro_pago
  import pago_pkg::*;
#(
  parameter int W   = 8,
  parameter int TMO = 200
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         EFE,
  input  logic         TAR,
  input  logic [W-1:0] PRECIO,
  input  logic         M1,
  input  logic         M5,
  input  logic         M10,
  input  logic         CAN,
  input  logic         APR,
  input  logic         RCH,
  output logic         OK,
  output logic         ERR,
  output logic         DEV,
  output logic [W-1:0] SALDO,
  output logic         OCUP,
  output dbg_t         dbg
);

  localparam logic [W-1:0] TMO_INI = W'(TMO - 1);

  // Handshake: none. EFE/TAR are levels sampled only in ESP; coin, CAN, APR
  // and RCH are single-cycle pulses sampled on the rising edge of clk.

  estado_t      estado_q, estado_d;
  logic [W-1:0] precio_q, precio_d;
  logic [W-1:0] saldo_q, saldo_d;
  logic         canc_q, canc_d;
  logic         ok_q, err_q, dev_q, ocup_q;

  logic         vuel_load, vuel_dec, vuel_zero, vuel_one;
  logic [W-1:0] vuel_val;
  logic         tmo_load, tmo_dec, tmo_zero, tmo_one;

  logic [W:0]   suma;
  logic [W-1:0] saldo_sat;
  logic [W-1:0] cambio;

  // Sum kept one bit wider so saturation and the price compare see the carry.
  always_comb begin
    suma      = {1'b0, saldo_q} + (W+1)'(valor_monedas(M1, M5, M10));
    saldo_sat = suma[W] ? {W{1'b1}} : suma[W-1:0];
    cambio    = W'(suma - {1'b0, precio_q});
  end

  always_comb begin
    estado_d  = estado_q;
    precio_d  = precio_q;
    saldo_d   = saldo_q;
    canc_d    = canc_q;
    vuel_load = 1'b0;
    vuel_val  = '0;
    vuel_dec  = 1'b0;
    tmo_load  = 1'b0;
    tmo_dec   = 1'b0;
    case (estado_q)
      ESP: begin
        if (EFE || TAR) begin
          precio_d = PRECIO;
          saldo_d  = '0;
          canc_d   = 1'b0;
          if (EFE) begin
            estado_d = CAJA;
          end else begin
            estado_d = TARJ;
            tmo_load = 1'b1;
          end
        end
      end
      CAJA: begin
        if (CAN) begin
          canc_d = 1'b1;
          if (saldo_q != '0) begin
            estado_d  = VUEL;
            vuel_load = 1'b1;
            vuel_val  = saldo_q;
          end else begin
            estado_d = FALLO;
          end
        end else begin
          saldo_d = saldo_sat;
          if (suma >= {1'b0, precio_q}) begin
            if (cambio != '0) begin
              estado_d  = VUEL;
              vuel_load = 1'b1;
              vuel_val  = cambio;
            end else begin
              estado_d = FIN;
            end
          end
        end
      end
      TARJ: begin
        tmo_dec = 1'b1;
        if (APR)
          estado_d = FIN;
        else if (RCH || CAN || tmo_zero)
          estado_d = FALLO;
      end
      VUEL: begin
        vuel_dec = 1'b1;
        // A zero count cannot occur on a legal path; leave rather than stall.
        if (vuel_one || vuel_zero)
          estado_d = canc_q ? FALLO : FIN;
      end
      FIN, FALLO: begin
        estado_d = ESP;
        saldo_d  = '0;
      end
      default: estado_d = ESP;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q <= ESP;
      precio_q <= '0;
      saldo_q  <= '0;
      canc_q   <= 1'b0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
      dev_q    <= 1'b0;
      ocup_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      precio_q <= precio_d;
      saldo_q  <= saldo_d;
      canc_q   <= canc_d;
      ok_q     <= (estado_d == FIN);
      err_q    <= (estado_d == FALLO);
      dev_q    <= (estado_d == VUEL);
      ocup_q   <= (estado_d != ESP);
    end
  end

  contador_desc #(.W(W)) u_vuelto (
    .clk  (clk),
    .rst  (reset),
    .load (vuel_load),
    .val  (vuel_val),
    .dec  (vuel_dec),
    .zero (vuel_zero),
    .one  (vuel_one)
  );

  contador_desc #(.W(W)) u_timeout (
    .clk  (clk),
    .rst  (reset),
    .load (tmo_load),
    .val  (TMO_INI),
    .dec  (tmo_dec),
    .zero (tmo_zero),
    .one  (tmo_one)
  );

  assign OK    = ok_q;
  assign ERR   = err_q;
  assign DEV   = dev_q;
  assign OCUP  = ocup_q;
  assign SALDO = saldo_q;

  assign dbg.estado    = estado_q;
  assign dbg.canc      = canc_q;
  assign dbg.vuel_one  = vuel_one;
  assign dbg.vuel_zero = vuel_zero;
  assign dbg.tmo_one   = tmo_one;
  assign dbg.tmo_zero  = tmo_zero;

endmodule

// File: tb/tb_cobro_pago.sv
// Bench for cobro_pago: directed vector table, corner sequences, and random
// transactions checked against a transaction-level model.
module tb_cobro_pago;
  import pago_pkg::*;

  localparam int W   = 8;
  localparam int TMO = 200;

  logic         clk, reset;
  logic         EFE, TAR, M1, M5, M10, CAN, APR, RCH;
  logic [W-1:0] PRECIO;
  logic         OK, ERR, DEV, OCUP;
  logic [W-1:0] SALDO;
  dbg_t         dbg;

  int errores = 0;
  int checks  = 0;

  // stimulus {EFE,TAR,PRECIO,M1,M5,M10,CAN,APR,RCH}; expected {OK,ERR,DEV,OCUP,SALDO}
  logic [15:0] stim_q[$];
  logic [11:0] exp_q[$];

  typedef struct {
    logic [15:0] s;
    logic [11:0] e;
  } vec_t;
  vec_t tabla[$];

  cobro_pago #(.W(W), .TMO(TMO)) dut (
    .clk(clk), .reset(reset), .EFE(EFE), .TAR(TAR), .PRECIO(PRECIO),
    .M1(M1), .M5(M5), .M10(M10), .CAN(CAN), .APR(APR), .RCH(RCH),
    .OK(OK), .ERR(ERR), .DEV(DEV), .SALDO(SALDO), .OCUP(OCUP), .dbg(dbg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] mk(input logic efe, input logic tar, input int p,
                                     input logic m1, input logic m5, input logic m10,
                                     input logic can, input logic apr, input logic rch);
    return {efe, tar, 8'(p), m1, m5, m10, can, apr, rch};
  endfunction

  function automatic logic [11:0] ex(input logic ok, input logic err, input logic dev,
                                     input logic ocup, input int saldo);
    return {ok, err, dev, ocup, 8'(saldo)};
  endfunction

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  // Arbitrary inputs for cycles where the block must ignore all of them.
  function automatic logic [15:0] junk();
    return mk(rb(), rb(), $urandom_range(0, 255), rb(), rb(), rb(), rb(), rb(), rb());
  endfunction

  function automatic logic [15:0] idle();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic drive(input logic [15:0] s);
    {EFE, TAR, PRECIO, M1, M5, M10, CAN, APR, RCH} = s;
  endtask

  task automatic paso(input logic [15:0] s, input logic [11:0] e, input string tag);
    logic [11:0] got;
    drive(s);
    @(posedge clk);
    @(negedge clk);
    got = {OK, ERR, DEV, OCUP, SALDO};
    checks++;
    if (got !== e) begin
      errores++;
      $display("FAIL %s: got ok=%b err=%b dev=%b ocup=%b saldo=%0d, want ok=%b err=%b dev=%b ocup=%b saldo=%0d",
               tag, got[11], got[10], got[9], got[8], got[7:0],
               e[11], e[10], e[9], e[8], e[7:0]);
    end
  endtask

  task automatic add(input logic [15:0] s, input logic [11:0] e);
    vec_t v;
    v.s = s;
    v.e = e;
    tabla.push_back(v);
  endtask

  task automatic push(input logic [15:0] s, input logic [11:0] e);
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  // Cash transaction: credit accumulates until it covers the price, change is
  // paid one unit per cycle, cancel refunds the credit held so far.
  task automatic gen_caja();
    int p, credit, ch, guard;
    bit done;
    logic m1, m5, m10, can;
    logic [15:0] s;
    p      = $urandom_range(0, 30);
    credit = 0;
    done   = 0;
    guard  = 0;
    push(mk(1, rb(), p, rb(), rb(), rb(), rb(), rb(), rb()), ex(0, 0, 0, 1, 0));
    while (!done) begin
      m1  = ($urandom_range(0, 9) < 3);
      m5  = ($urandom_range(0, 9) < 3);
      m10 = ($urandom_range(0, 9) < 2);
      can = ($urandom_range(0, 19) == 0);
      guard++;
      if (guard > 60) can = 1'b1;
      s = mk(rb(), rb(), $urandom_range(0, 255), m1, m5, m10, can, rb(), rb());
      if (can) begin
        if (credit > 0) begin
          push(s, ex(0, 0, 1, 1, credit));
          for (int i = 1; i < credit; i++) push(junk(), ex(0, 0, 1, 1, credit));
          push(junk(), ex(0, 1, 0, 1, credit));
        end else begin
          push(s, ex(0, 1, 0, 1, 0));
        end
        done = 1;
      end else begin
        credit += int'(m1) + 5 * int'(m5) + 10 * int'(m10);
        if (credit >= p) begin
          ch = credit - p;
          if (ch > 0) begin
            push(s, ex(0, 0, 1, 1, credit));
            for (int i = 1; i < ch; i++) push(junk(), ex(0, 0, 1, 1, credit));
            push(junk(), ex(1, 0, 0, 1, credit));
          end else begin
            push(s, ex(1, 0, 0, 1, credit));
          end
          done = 1;
        end else begin
          push(s, ex(0, 0, 0, 1, credit));
        end
      end
    end
    push(junk(), ex(0, 0, 0, 0, 0));
  endtask

  // Card transaction: a verdict (approve, reject or cancel) arrives well
  // before the timeout; approve beats anything else in the same cycle.
  task automatic gen_tarjeta();
    int d, r;
    push(mk(0, 1, $urandom_range(0, 255), rb(), rb(), rb(), rb(), rb(), rb()), ex(0, 0, 0, 1, 0));
    d = $urandom_range(0, 10);
    for (int i = 0; i < d; i++)
      push(mk(rb(), rb(), $urandom_range(0, 255), rb(), rb(), rb(), 0, 0, 0), ex(0, 0, 0, 1, 0));
    r = $urandom_range(0, 2);
    if (r == 0)
      push(mk(rb(), rb(), 0, rb(), rb(), rb(), rb(), 1, rb()), ex(1, 0, 0, 1, 0));
    else if (r == 1)
      push(mk(rb(), rb(), 0, rb(), rb(), rb(), rb(), 0, 1), ex(0, 1, 0, 1, 0));
    else
      push(mk(rb(), rb(), 0, rb(), rb(), rb(), 1, 0, 0), ex(0, 1, 0, 1, 0));
    push(junk(), ex(0, 0, 0, 0, 0));
  endtask

  initial begin
    reset = 1'b1;
    drive(idle());
    repeat (2) @(negedge clk);
    checks++;
    if ({OK, ERR, DEV, OCUP, SALDO} !== 12'd0 || dbg.estado !== ESP) begin
      errores++;
      $display("FAIL reset_state: got outs=%h state=%0d, want outs=0 state=0",
               {OK, ERR, DEV, OCUP, SALDO}, dbg.estado);
    end
    reset = 1'b0;

    // Price 12, coins 10 then 5: three units of change.
    add(mk(1, 0, 12, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 1, 0));
    add(mk(0, 0, 0, 0, 0, 1, 0, 0, 0), ex(0, 0, 0, 1, 10));
    add(mk(0, 0, 0, 0, 1, 0, 0, 0, 0), ex(0, 0, 1, 1, 15));
    add(idle(), ex(0, 0, 1, 1, 15));
    add(idle(), ex(0, 0, 1, 1, 15));
    add(idle(), ex(1, 0, 0, 1, 15));
    add(idle(), ex(0, 0, 0, 0, 0));
    // Price 15, two coins together: exact payment.
    add(mk(1, 0, 15, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 1, 0));
    add(mk(0, 0, 0, 0, 1, 1, 0, 0, 0), ex(1, 0, 0, 1, 15));
    add(idle(), ex(0, 0, 0, 0, 0));
    // Price 20, 5 + 1, cancel with a coin that must not count.
    add(mk(1, 0, 20, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 1, 0));
    add(mk(0, 0, 0, 0, 1, 0, 0, 0, 0), ex(0, 0, 0, 1, 5));
    add(mk(0, 0, 0, 1, 0, 0, 0, 0, 0), ex(0, 0, 0, 1, 6));
    add(mk(0, 0, 0, 0, 0, 1, 1, 0, 0), ex(0, 0, 1, 1, 6));
    for (int i = 0; i < 5; i++) add(idle(), ex(0, 0, 1, 1, 6));
    add(idle(), ex(0, 1, 0, 1, 6));
    add(idle(), ex(0, 0, 0, 0, 0));
    // Card approved after a few cycles.
    add(mk(0, 1, 50, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 1, 0));
    for (int i = 0; i < 4; i++) add(idle(), ex(0, 0, 0, 1, 0));
    add(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), ex(1, 0, 0, 1, 0));
    add(idle(), ex(0, 0, 0, 0, 0));
    // Card rejected.
    add(mk(0, 1, 50, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 1, 0));
    add(mk(0, 0, 0, 0, 0, 0, 0, 0, 1), ex(0, 1, 0, 1, 0));
    add(idle(), ex(0, 0, 0, 0, 0));
    // Price 0: OK on the second cycle after selection.
    add(mk(1, 0, 0, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 1, 0));
    add(idle(), ex(1, 0, 0, 1, 0));
    add(idle(), ex(0, 0, 0, 0, 0));
    // EFE and TAR together take the cash path.
    add(mk(1, 1, 0, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 1, 0));
    add(idle(), ex(1, 0, 0, 1, 0));
    add(idle(), ex(0, 0, 0, 0, 0));
    // Coins and EFE during a card wait are ignored.
    add(mk(0, 1, 9, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 1, 0));
    add(mk(0, 0, 0, 0, 0, 1, 0, 0, 0), ex(0, 0, 0, 1, 0));
    add(mk(1, 0, 0, 1, 0, 0, 0, 0, 0), ex(0, 0, 0, 1, 0));
    add(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), ex(1, 0, 0, 1, 0));
    add(idle(), ex(0, 0, 0, 0, 0));
    // Cancel with no credit fails directly.
    add(mk(1, 0, 7, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 1, 0));
    add(mk(0, 0, 0, 0, 0, 0, 1, 0, 0), ex(0, 1, 0, 1, 0));
    add(idle(), ex(0, 0, 0, 0, 0));
    // Price 0 with a coin on the first collecting cycle: all of it returned.
    add(mk(1, 0, 0, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 1, 0));
    add(mk(0, 0, 0, 0, 1, 0, 0, 0, 0), ex(0, 0, 1, 1, 5));
    for (int i = 0; i < 4; i++) add(idle(), ex(0, 0, 1, 1, 5));
    add(idle(), ex(1, 0, 0, 1, 5));
    add(idle(), ex(0, 0, 0, 0, 0));

    for (int i = 0; i < tabla.size(); i++)
      paso(tabla[i].s, tabla[i].e, $sformatf("vec%0d", i));

    // Card timeout: ERR exactly TMO cycles after entering the wait.
    paso(mk(0, 1, 3, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 1, 0), "tmo_entry");
    for (int k = 1; k < TMO; k++) paso(idle(), ex(0, 0, 0, 1, 0), "tmo_wait");
    paso(idle(), ex(0, 1, 0, 1, 0), "tmo_err");
    paso(idle(), ex(0, 0, 0, 0, 0), "tmo_idle");

    // Approval on the expiry cycle wins over the timeout.
    paso(mk(0, 1, 3, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 1, 0), "tmo_apr_entry");
    for (int k = 1; k < TMO; k++) paso(idle(), ex(0, 0, 0, 1, 0), "tmo_apr_wait");
    paso(mk(0, 0, 0, 0, 0, 0, 0, 1, 0), ex(1, 0, 0, 1, 0), "tmo_apr_ok");
    paso(idle(), ex(0, 0, 0, 0, 0), "tmo_apr_idle");

    // Reset while returning change: everything clears at once.
    paso(mk(1, 0, 4, 0, 0, 0, 0, 0, 0), ex(0, 0, 0, 1, 0), "rst_entry");
    paso(mk(0, 0, 0, 0, 0, 1, 0, 0, 0), ex(0, 0, 1, 1, 10), "rst_dev1");
    paso(idle(), ex(0, 0, 1, 1, 10), "rst_dev2");
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({OK, ERR, DEV, OCUP, SALDO} !== 12'd0 || dbg.estado !== ESP) begin
      errores++;
      $display("FAIL rst_async: got outs=%h state=%0d, want outs=0 state=0",
               {OK, ERR, DEV, OCUP, SALDO}, dbg.estado);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) paso(idle(), ex(0, 0, 0, 0, 0), "rst_quiet");

    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(0, 2) == 0) gen_tarjeta();
      else                            gen_caja();
    end
    while (stim_q.size() > 0)
      paso(stim_q.pop_front(), exp_q.pop_front(), "rnd");

    $display("Result: errors=%0d of %0d checks", errores, checks);
    $finish;
  end

endmodule
